decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised, buffered RV32I instruction decode stage that sits between fetch and execute. Fetched `{instr, pc}` pairs enter a DEPTH-entry queue over a valid/ready handshake. The head entry is decoded into a full control bundle with sign-extended immediates and register indices. The bundle is held in an output register with its own valid/ready handshake, so fetch and execute stalls are decoupled.

## Interface
- `XLEN`, default 32: pc and immediate width; must be ≥ 32.
- `DEPTH`, default 4: queue entries; must be a power of 2 and ≥ 2.
- `clk` in 1: clock, rising edge.
- `nRst` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous discard of all queued and registered instructions.
- `in_valid` in 1: fetch offers `in_instr`/`in_pc`.
- `in_ready` out 1: queue can accept.
- `in_instr` in 32: raw instruction.
- `in_pc` in XLEN: pc of `in_instr`.
- `count` out $clog2(DEPTH)+1: queue occupancy, excluding the output register.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `out_pc` out XLEN: pc of the decoded instruction.
- `cu_op` out cu_op_t: instruction class; `CU_ERROR` when illegal.
- `alu_op` out alu_op_t: ALU function.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `alu_src`, `is_signed`, `illegal` out 1 each: control flags.
- `imm` out XLEN: immediate, sign-extended and format-assembled.
- `rs1`, `rs2`, `rd` out 5 each: register indices; 0 when the format does not use them.

## Operation
- Queue: circular buffer of `{instr, pc}` with read/write pointers and a count.
  - `in_ready = (count != DEPTH)`.
  - Push on `in_valid && in_ready`.
  - No same-cycle bypass when full: a pop does not make room for a push in the same cycle.
- Output register load: loads the decode of the head when `count != 0 && (!out_valid || out_ready)`; that head is popped.
  - Otherwise, when `out_valid && out_ready`, `out_valid` clears.
  - The bundle holds stable while `out_valid && !out_ready`.
- Immediates:
  - I: `sext(instr[31:20])`.
  - S: `sext({instr[31:25], instr[11:7]})`.
  - B: `sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})`.
  - U: `{instr[31:12], 12'b0}` sign-extended to XLEN.
  - J: `sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})`.
- Class rules:
  - LUI, AUIPC, JAL: `reg_write=1`, `rd` set.
  - JALR: `reg_write=1`, `rs1` and `rd` set, I-imm.
  - Branch: `branch=1`, `alu_op=ALU_SUB`, `rs1`/`rs2`, B-imm.
  - Load: `reg_write=1`, `mem_read=1`, `alu_src=1`, `alu_op=ALU_ADD`.
  - Store: `mem_write=1`, `alu_src=1`, `alu_op=ALU_ADD`, `rs1`/`rs2`, S-imm.
  - OP-IMM: `reg_write=1`, `alu_src=1`. SRAI only for funct3=101 with `instr[30]=1`. SLLI/SRLI/SRAI require `instr[31:25]` ∈ {0000000, 0100000 (SRAI only)}.
  - OP: `reg_write=1`. `instr[30]` selects SUB/SRA; any other nonzero funct7 is illegal.
- `is_signed=1` for LB, LH, BLT, BGE, SLT, SLTI, SRA, SRAI.
- Illegal (unknown opcode, funct3 or funct7):
  - `illegal=1`, `cu_op=CU_ERROR`.
  - All write/read/branch flags are 0.
  - Still delivered with `out_valid`; never dropped.

## Timing
- Reset (`nRst` low, asynchronous): pointers and `count` = 0, `out_valid` = 0, all bundle fields = 0, `cu_op` = `CU_ERROR`, `in_ready` = 1 once count is 0.
- Latency: an instruction pushed at edge N is presented with `out_valid=1` after edge N+1, provided the output register is free.
- Throughput: 1 instruction/cycle sustained with `out_ready` held high.
- `flush` is highest priority. At the edge: `count` = 0, pointers reset, `out_valid` = 0. A push or pop in that same cycle is discarded.
- Pointers wrap modulo DEPTH. `count` saturates at neither bound by design; push at full and pop at empty are impossible.

## Configuration
- `DECODE_MEXT_EN` defined: OP with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `cu_op`/`alu_op` take the matching cpu_pkg M-codes, with `reg_write=1`.
  - `is_signed=1` for MULH, DIV, REM.
- Undefined: those encodings are illegal (`CU_ERROR`).

## Test plan
- Reset, then push `addi x1,x0,-1` (0xFFF00093) -> 2nd edge after push: `out_valid=1`, `imm=0xFFFFFFFF`, `rd=1`, `reg_write=1`, `alu_src=1`, `mem_write=0`.
- Push `beq x1,x2,-4` (0xFE208EE3) -> `branch=1`, `imm=0xFFFFFFFC`, `rs1=1`, `rs2=2`, `alu_op=ALU_SUB`.
- Hold `out_ready=0`, push DEPTH+1 instructions -> `in_ready=0` once `count=DEPTH`; bundle stable. Release -> instructions emerge in order, one per cycle, pcs intact.
- Assert `flush` with a full queue and a simultaneous push -> next cycle `count=0`, `out_valid=0`, `in_ready=1`; the pushed instruction never appears.
- Push 0x02208033 (`mul x0,x1,x2`) -> with `DECODE_MEXT_EN`: M-code and `illegal=0`; without it: `illegal=1`, `cu_op=CU_ERROR`, `reg_write=0`.
- Deassert `nRst` mid-stream with `out_valid=1` -> immediately `out_valid=0`, `count=0`, before any clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: buffered RV32I decode stage between fetch and execute.
// Fetched {instr, pc} pairs wait in a DEPTH-entry circular queue; the head is
// decoded into a control bundle that sits in an output register with its own
// valid/ready handshake, so fetch and execute stalls are decoupled.
// Optional feature: define DECODE_MEXT_EN to decode the RV32M multiply/divide
// group (OP with funct7=0000001); without it those encodings are illegal.

package cpu_pkg;

    typedef enum logic [4:0] {
        CU_ERROR,
        CU_LUI,
        CU_AUIPC,
        CU_JAL,
        CU_JALR,
        CU_BRANCH,
        CU_LOAD,
        CU_STORE,
        CU_OPIMM,
        CU_OP,
        CU_MUL,
        CU_MULH,
        CU_MULHSU,
        CU_MULHU,
        CU_DIV,
        CU_DIVU,
        CU_REM,
        CU_REMU
    } cu_op_t;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

endpackage

module decode_queue
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output cu_op_t                   cu_op,
    output alu_op_t                  alu_op,
    output logic                     reg_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     branch,
    output logic                     alu_src,
    output logic                     is_signed,
    output logic                     illegal,
    output logic [XLEN-1:0]          imm,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            push;
    logic            pop;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm_i;
    logic [31:0]     imm_s;
    logic [31:0]     imm_b;
    logic [31:0]     imm_u;
    logic [31:0]     imm_j;

    cu_op_t          d_cu_op;
    alu_op_t         d_alu_op;
    logic            d_reg_write;
    logic            d_mem_read;
    logic            d_mem_write;
    logic            d_branch;
    logic            d_alu_src;
    logic            d_is_signed;
    logic            d_illegal;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [4:0]      d_rd;
    logic            bad;

    // A full queue never accepts, even if the head is leaving this cycle.
    assign in_ready   = (count != CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (count != '0) && (!out_valid || out_ready);

    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign funct7     = head_instr[31:25];

    assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
    assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
    assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                    head_instr[30:25], head_instr[11:8], 1'b0};
    assign imm_u = {head_instr[31:12], 12'b0};
    assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                    head_instr[20], head_instr[30:21], 1'b0};

    // Queue storage: entries are written at the write pointer on a push.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode the head entry; any unknown encoding collapses to a clean illegal bundle.
    always_comb begin
        d_cu_op     = CU_ERROR;
        d_alu_op    = ALU_ADD;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_alu_src   = 1'b0;
        d_is_signed = 1'b0;
        d_illegal   = 1'b0;
        d_imm       = '0;
        d_rs1       = '0;
        d_rs2       = '0;
        d_rd        = '0;
        bad         = 1'b0;

        case (opcode)
            7'b0110111: begin
                d_cu_op     = CU_LUI;
                d_reg_write = 1'b1;
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_u));
            end
            7'b0010111: begin
                d_cu_op     = CU_AUIPC;
                d_reg_write = 1'b1;
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_u));
            end
            7'b1101111: begin
                d_cu_op     = CU_JAL;
                d_reg_write = 1'b1;
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_j));
            end
            7'b1100111: begin
                d_cu_op     = CU_JALR;
                d_reg_write = 1'b1;
                d_rs1       = head_instr[19:15];
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_i));
                bad         = (funct3 != 3'b000);
            end
            7'b1100011: begin
                d_cu_op  = CU_BRANCH;
                d_branch = 1'b1;
                d_alu_op = ALU_SUB;
                d_rs1    = head_instr[19:15];
                d_rs2    = head_instr[24:20];
                d_imm    = XLEN'($signed(imm_b));
                case (funct3)
                    3'b000, 3'b001, 3'b110, 3'b111: d_is_signed = 1'b0;
                    3'b100, 3'b101:                 d_is_signed = 1'b1;
                    default:                        bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                d_cu_op     = CU_LOAD;
                d_reg_write = 1'b1;
                d_mem_read  = 1'b1;
                d_alu_src   = 1'b1;
                d_rs1       = head_instr[19:15];
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_i));
                case (funct3)
                    3'b000, 3'b001:         d_is_signed = 1'b1;
                    3'b010, 3'b100, 3'b101: d_is_signed = 1'b0;
                    default:                bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                d_cu_op     = CU_STORE;
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
                d_rs1       = head_instr[19:15];
                d_rs2       = head_instr[24:20];
                d_imm       = XLEN'($signed(imm_s));
                bad         = (funct3 > 3'b010);
            end
            7'b0010011: begin
                d_cu_op     = CU_OPIMM;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_rs1       = head_instr[19:15];
                d_rd        = head_instr[11:7];
                d_imm       = XLEN'($signed(imm_i));
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: begin
                        d_alu_op    = ALU_SLT;
                        d_is_signed = 1'b1;
                    end
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin
                        d_alu_op = ALU_SLL;
                        bad      = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            d_alu_op = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            d_alu_op    = ALU_SRA;
                            d_is_signed = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                endcase
            end
            7'b0110011: begin
                d_cu_op     = CU_OP;
                d_reg_write = 1'b1;
                d_rs1       = head_instr[19:15];
                d_rs2       = head_instr[24:20];
                d_rd        = head_instr[11:7];
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: d_alu_op = ALU_ADD;
                        3'b001: d_alu_op = ALU_SLL;
                        3'b010: begin
                            d_alu_op    = ALU_SLT;
                            d_is_signed = 1'b1;
                        end
                        3'b011: d_alu_op = ALU_SLTU;
                        3'b100: d_alu_op = ALU_XOR;
                        3'b101: d_alu_op = ALU_SRL;
                        3'b110: d_alu_op = ALU_OR;
                        default: d_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        d_alu_op = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        d_alu_op    = ALU_SRA;
                        d_is_signed = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
`ifdef DECODE_MEXT_EN
                else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000: begin
                            d_cu_op  = CU_MUL;
                            d_alu_op = ALU_MUL;
                        end
                        3'b001: begin
                            d_cu_op     = CU_MULH;
                            d_alu_op    = ALU_MULH;
                            d_is_signed = 1'b1;
                        end
                        3'b010: begin
                            d_cu_op  = CU_MULHSU;
                            d_alu_op = ALU_MULHSU;
                        end
                        3'b011: begin
                            d_cu_op  = CU_MULHU;
                            d_alu_op = ALU_MULHU;
                        end
                        3'b100: begin
                            d_cu_op     = CU_DIV;
                            d_alu_op    = ALU_DIV;
                            d_is_signed = 1'b1;
                        end
                        3'b101: begin
                            d_cu_op  = CU_DIVU;
                            d_alu_op = ALU_DIVU;
                        end
                        3'b110: begin
                            d_cu_op     = CU_REM;
                            d_alu_op    = ALU_REM;
                            d_is_signed = 1'b1;
                        end
                        default: begin
                            d_cu_op  = CU_REMU;
                            d_alu_op = ALU_REMU;
                        end
                    endcase
                end
`endif
                else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            d_cu_op     = CU_ERROR;
            d_alu_op    = ALU_ADD;
            d_reg_write = 1'b0;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_branch    = 1'b0;
            d_alu_src   = 1'b0;
            d_is_signed = 1'b0;
            d_illegal   = 1'b1;
            d_imm       = '0;
            d_rs1       = '0;
            d_rs2       = '0;
            d_rd        = '0;
        end
    end

    // Output register: load the decoded head when free or draining, hold while stalled.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            cu_op     <= CU_ERROR;
            alu_op    <= ALU_ADD;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            branch    <= 1'b0;
            alu_src   <= 1'b0;
            is_signed <= 1'b0;
            illegal   <= 1'b0;
            imm       <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_pc    <= head_pc;
            cu_op     <= d_cu_op;
            alu_op    <= d_alu_op;
            reg_write <= d_reg_write;
            mem_read  <= d_mem_read;
            mem_write <= d_mem_write;
            branch    <= d_branch;
            alu_src   <= d_alu_src;
            is_signed <= d_is_signed;
            illegal   <= d_illegal;
            imm       <= d_imm;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            rd        <= d_rd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table of hand-decoded RV32I instructions streamed through
// decode_queue, checked by a scoreboard, plus backpressure, flush and
// asynchronous-reset sequences.
module tb_decode_queue;
    import cpu_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    // flags order: reg_write, mem_read, mem_write, branch, alu_src, is_signed, illegal
    typedef struct packed {
        logic [31:0] instr;
        cu_op_t      cu;
        alu_op_t     alu;
        logic [6:0]  flags;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [31:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            nRst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [CW-1:0]   count;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    cu_op_t          cu_op;
    alu_op_t         alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            alu_src;
    logic            is_signed;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;

    int              tests = 0;
    int              fails = 0;
    int              pops  = 0;
    exp_t            sb[$];
    vec_t            tbl[$];
    vec_t            cur_vec;
    logic [31:0]     cur_pc;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .nRst(nRst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .count(count), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .cu_op(cu_op), .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .alu_src(alu_src), .is_signed(is_signed),
        .illegal(illegal), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] instr, input cu_op_t cu, input alu_op_t alu,
                                input logic [6:0] flags, input logic [31:0] immv,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        vec_t v;
        v.instr = instr;
        v.cu    = cu;
        v.alu   = alu;
        v.flags = flags;
        v.imm   = immv;
        v.rs1   = s1;
        v.rs2   = s2;
        v.rd    = d;
        return v;
    endfunction

    function automatic vec_t mkIll(input logic [31:0] instr);
        return mk(instr, CU_ERROR, ALU_ADD, 7'b0000001, 32'h0, 5'd0, 5'd0, 5'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Illegal bundles only pin down class, the write/read/branch flags, illegal and pc.
    task automatic checkBundle(input exp_t e);
        logic [95:0] got;
        logic [95:0] exp;
        logic [95:0] mask;
        got  = {cu_op, alu_op, reg_write, mem_read, mem_write, branch, alu_src,
                is_signed, illegal, imm, rs1, rs2, rd, out_pc};
        exp  = {e.v.cu, e.v.alu, e.v.flags, e.v.imm, e.v.rs1, e.v.rs2, e.v.rd, e.pc};
        mask = e.v.flags[0] ? {5'h1f, 5'h00, 7'b1111001, 32'h0, 15'h0, 32'hffffffff} : '1;
        checkOutput($sformatf("bundle instr=%h pc=%h", e.v.instr, e.pc), got & mask, exp & mask);
    endtask

    // Scoreboard: record accepted pushes, compare on every accepted output.
    always @(negedge clk) begin
        if (nRst) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    pops++;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected output: got pc=%h, expected no output", out_pc);
                    end else begin
                        checkBundle(sb.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back({cur_vec, cur_pc});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
        int waited;
        waited   = 0;
        cur_vec  = v;
        cur_pc   = pc;
        in_instr = v.instr;
        in_pc    = pc;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL push timeout: in_ready=%b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited    = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && waited < 40) begin
            step();
            waited++;
        end
        checkOutput({name, " drained"}, 96'(sb.size()), 96'd0);
        checkOutput({name, " out_valid idle"}, 96'(out_valid), 96'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl.push_back(mk(32'hFFF00093, CU_OPIMM,  ALU_ADD,  7'b1000100, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1));
        tbl.push_back(mk(32'hFE208EE3, CU_BRANCH, ALU_SUB,  7'b0001000, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0));
        tbl.push_back(mk(32'h00812283, CU_LOAD,   ALU_ADD,  7'b1100100, 32'h00000008, 5'd2, 5'd0, 5'd5));
        tbl.push_back(mk(32'hFFF10283, CU_LOAD,   ALU_ADD,  7'b1100110, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd5));
        tbl.push_back(mk(32'hFE322C23, CU_STORE,  ALU_ADD,  7'b0010100, 32'hFFFFFFF8, 5'd4, 5'd3, 5'd0));
        tbl.push_back(mk(32'h123453B7, CU_LUI,    ALU_ADD,  7'b1000000, 32'h12345000, 5'd0, 5'd0, 5'd7));
        tbl.push_back(mk(32'h80000417, CU_AUIPC,  ALU_ADD,  7'b1000000, 32'h80000000, 5'd0, 5'd0, 5'd8));
        tbl.push_back(mk(32'h001000EF, CU_JAL,    ALU_ADD,  7'b1000000, 32'h00000800, 5'd0, 5'd0, 5'd1));
        tbl.push_back(mk(32'h00408067, CU_JALR,   ALU_ADD,  7'b1000000, 32'h00000004, 5'd1, 5'd0, 5'd0));
        tbl.push_back(mk(32'h0062C863, CU_BRANCH, ALU_SUB,  7'b0001010, 32'h00000010, 5'd5, 5'd6, 5'd0));
        tbl.push_back(mk(32'h40525193, CU_OPIMM,  ALU_SRA,  7'b1000110, 32'h00000405, 5'd4, 5'd0, 5'd3));
        tbl.push_back(mk(32'hFFB12093, CU_OPIMM,  ALU_SLT,  7'b1000110, 32'hFFFFFFFB, 5'd2, 5'd0, 5'd1));
        tbl.push_back(mk(32'h403100B3, CU_OP,     ALU_SUB,  7'b1000000, 32'h00000000, 5'd2, 5'd3, 5'd1));
        tbl.push_back(mk(32'h403150B3, CU_OP,     ALU_SRA,  7'b1000010, 32'h00000000, 5'd2, 5'd3, 5'd1));
        tbl.push_back(mk(32'h0062B233, CU_OP,     ALU_SLTU, 7'b1000000, 32'h00000000, 5'd5, 5'd6, 5'd4));
        tbl.push_back(mkIll(32'h40521193));
        tbl.push_back(mkIll(32'h04000033));
        tbl.push_back(mkIll(32'h0000007F));
        tbl.push_back(mkIll(32'h00003023));
        tbl.push_back(mkIll(32'h00003003));
        tbl.push_back(mkIll(32'h00001067));
`ifdef DECODE_MEXT_EN
        tbl.push_back(mk(32'h02208033, CU_MUL,    ALU_MUL,  7'b1000000, 32'h00000000, 5'd1, 5'd2, 5'd0));
`else
        tbl.push_back(mkIll(32'h02208033));
`endif

        nRst      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        cur_vec   = tbl[0];
        cur_pc    = '0;

        #12;
        checkOutput("reset out_valid", 96'(out_valid), 96'd0);
        checkOutput("reset count", 96'(count), 96'd0);
        checkOutput("reset in_ready", 96'(in_ready), 96'd1);
        checkOutput("reset cu_op", 96'(cu_op), 96'(CU_ERROR));
        checkOutput("reset imm/rd", {64'(imm), 27'd0, rd}, 96'd0);
        @(negedge clk);
        nRst = 1'b1;
        step();

        // Latency: pushed at edge N, visible after edge N+1.
        applyStimulus(tbl[0], 32'h0000_0100);
        checkOutput("latency out_valid after push edge", 96'(out_valid), 96'd0);
        checkOutput("latency count after push edge", 96'(count), 96'd1);
        step();
        checkOutput("latency out_valid next edge", 96'(out_valid), 96'd1);
        checkOutput("latency imm", 96'(imm), 96'hFFFFFFFF);
        drain("latency");

        // Full table streamed back to back; count stays at 1 if one leaves per cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], 32'h1000 + 32'(4 * i));
            checkOutput($sformatf("stream count %0d", i), 96'(count), 96'd1);
        end
        drain("stream");

        // Backpressure: DEPTH+1 accepted, then full and stalled bundle held.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(tbl[i + 2], 32'h2000 + 32'(4 * i));
        end
        checkOutput("full count", 96'(count), 96'(DEPTH));
        checkOutput("full in_ready", 96'(in_ready), 96'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall out_valid", 96'(out_valid), 96'd1);
            checkOutput("stall out_pc", 96'(out_pc), 96'h2000);
        end
        begin
            int pops0;
            pops0     = pops;
            out_ready = 1'b1;
            for (int i = 0; i < DEPTH + 1; i++) step();
            checkOutput("release one per cycle", 96'(pops - pops0), 96'(DEPTH + 1));
            checkOutput("release out_valid", 96'(out_valid), 96'd0);
        end
        drain("backpressure");

        // Flush with a partially filled queue and a simultaneous accepted push.
        out_ready = 1'b0;
        applyStimulus(tbl[5], 32'h3000);
        applyStimulus(tbl[6], 32'h3004);
        cur_vec  = tbl[7];
        cur_pc   = 32'h3008;
        in_instr = tbl[7].instr;
        in_pc    = 32'h3008;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush count", 96'(count), 96'd0);
        checkOutput("flush out_valid", 96'(out_valid), 96'd0);
        checkOutput("flush in_ready", 96'(in_ready), 96'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checkOutput("flushed push absent", 96'(out_valid), 96'd0);

        // Flush with a full queue while fetch is still offering.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(tbl[i], 32'h4000 + 32'(4 * i));
        end
        checkOutput("pre-flush full", 96'(count), 96'(DEPTH));
        in_instr = tbl[9].instr;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush full count", 96'(count), 96'd0);
        checkOutput("flush full out_valid", 96'(out_valid), 96'd0);
        checkOutput("flush full in_ready", 96'(in_ready), 96'd1);
        out_ready = 1'b1;
        applyStimulus(tbl[1], 32'h5000);
        drain("after flush");

        // Asynchronous reset mid-cycle with a valid bundle waiting.
        out_ready = 1'b0;
        applyStimulus(tbl[2], 32'h6000);
        step();
        checkOutput("pre-reset out_valid", 96'(out_valid), 96'd1);
        #2;
        nRst = 1'b0;
        #1;
        checkOutput("async reset out_valid", 96'(out_valid), 96'd0);
        checkOutput("async reset count", 96'(count), 96'd0);
        checkOutput("async reset cu_op", 96'(cu_op), 96'(CU_ERROR));
        sb.delete();
        nRst = 1'b1;
        out_ready = 1'b1;
        step();
        applyStimulus(tbl[3], 32'h7000);
        drain("after reset");

        checkOutput("scoreboard empty", 96'(sb.size()), 96'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
